// File: rtl/lut_sweep_engine.sv
// lut_sweep_engine
//   Programmable truth-table unit. A 2**N_IN x N_OUT lookup table is loaded
//   through a write port. The table then answers single lookups, or sweeps
//   every input combination 0..2**N_IN-1 and streams the whole truth table
//   out through a valid/ready handshake.
//
// Parameters
//   N_IN   number of function inputs (1..8); table depth is 2**N_IN
//   N_OUT  number of function outputs (1..16)
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   cfg_we/addr/data      table write, accepted only when idle
//   in_valid/in_vec       single-lookup request
//   in_ready              lookup accepted when in_valid && in_ready
//   sweep_start           request a full truth-table sweep
//   busy                  high while sweeping or finishing a sweep
//   done                  one-cycle pulse when a sweep completes
//   out_valid/out_ready   output beat handshake
//   out_idx/out_data      input combination and table contents of the beat
//   out_last              final sweep beat; always 0 for lookups
module lut_sweep_engine #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [N_IN-1:0]  cfg_addr,
  input  logic [N_OUT-1:0] cfg_data,
  input  logic             in_valid,
  input  logic [N_IN-1:0]  in_vec,
  output logic             in_ready,
  input  logic             sweep_start,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_IN-1:0]  out_idx,
  output logic [N_OUT-1:0] out_data,
  output logic             out_last
);

  localparam int            DEPTH    = 1 << N_IN;
  localparam logic [N_IN:0] LAST_IDX = (N_IN + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t           state;
  logic [N_OUT-1:0] lut [DEPTH];
  // One bit wider than the index so the final beat is found by compare,
  // never by the counter rolling back to zero.
  logic [N_IN:0]    cnt;
  logic [N_IN:0]    cnt_next;
  logic             out_free;
  logic             out_fire;
  logic             lookup_go;
  logic             sweep_go;

  // The output register can take a new beat when empty or being drained now.
  assign out_free  = !out_valid || out_ready;
  assign out_fire  = out_valid && out_ready;
  assign in_ready  = (state == IDLE) && !sweep_start && out_free;
  assign lookup_go = in_valid && in_ready;
  // An unaccepted lookup result blocks the sweep until it drains.
  assign sweep_go  = (state == IDLE) && sweep_start && out_free;
  assign cnt_next  = cnt + 1'b1;
  assign busy      = (state != IDLE);

  // NOTE: the table has to come out of reset cleared, so every entry sits on
  // the async reset; this keeps it in flops instead of a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) lut[i] <= '0;
    end else if (cfg_we && state == IDLE) begin
      lut[cfg_addr] <= cfg_data;
    end
  end

  // NOTE: all state here uses non-blocking assignments, so the table reads
  // below see the pre-edge contents; a same-cycle write returns old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sweep_go) begin
            state     <= SWEEP;
            cnt       <= '0;
            out_valid <= 1'b1;
            out_idx   <= '0;
            out_data  <= lut[0];
            out_last  <= 1'b0;
          end else if (lookup_go) begin
            out_valid <= 1'b1;
            out_idx   <= in_vec;
            out_data  <= lut[in_vec];
            out_last  <= 1'b0;
          end else if (out_fire) begin
            out_valid <= 1'b0;
          end
        end
        SWEEP: begin
          if (out_fire) begin
            if (cnt == LAST_IDX) begin
              state     <= DONE;
              done      <= 1'b1;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              cnt      <= cnt_next;
              out_idx  <= cnt_next[N_IN-1:0];
              out_data <= lut[cnt_next[N_IN-1:0]];
              out_last <= (cnt_next == LAST_IDX);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_sweep_engine.sv
// Self-checking bench for lut_sweep_engine. The main instance (N_IN=3,
// N_OUT=2) is followed cycle by cycle by a behavioural model; two corner
// instances (1x1 and 8x4) are checked with directed sweeps.
module tb_lut_sweep_engine;

  localparam int DEPTH = 8;
  localparam int S_IDLE = 0, S_SWEEP = 1, S_DONE = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we, in_valid, sweep_start, out_ready;
  logic [2:0] cfg_addr, in_vec;
  logic [1:0] cfg_data;
  logic       in_ready, busy, done, out_valid, out_last;
  logic [2:0] out_idx;
  logic [1:0] out_data;

  logic       c1_cfg_we, c1_sweep_start, c1_out_ready;
  logic [0:0] c1_cfg_addr, c1_cfg_data;
  logic       c1_in_ready, c1_busy, c1_done, c1_out_valid, c1_out_last;
  logic [0:0] c1_out_idx, c1_out_data;

  logic       c8_cfg_we, c8_sweep_start, c8_out_ready;
  logic [7:0] c8_cfg_addr;
  logic [3:0] c8_cfg_data;
  logic       c8_in_ready, c8_busy, c8_done, c8_out_valid, c8_out_last;
  logic [7:0] c8_out_idx;
  logic [3:0] c8_out_data;

  logic       zero_valid = 1'b0;
  logic [0:0] zero_vec1  = '0;
  logic [7:0] zero_vec8  = '0;

  always #5 clk = ~clk;

  lut_sweep_engine #(.N_IN(3), .N_OUT(2)) u_dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_vec(in_vec), .in_ready(in_ready), .sweep_start(sweep_start),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_data(out_data), .out_last(out_last));

  lut_sweep_engine #(.N_IN(1), .N_OUT(1)) u_c1 (
    .clk(clk), .rst(rst), .cfg_we(c1_cfg_we), .cfg_addr(c1_cfg_addr), .cfg_data(c1_cfg_data),
    .in_valid(zero_valid), .in_vec(zero_vec1), .in_ready(c1_in_ready),
    .sweep_start(c1_sweep_start), .busy(c1_busy), .done(c1_done), .out_valid(c1_out_valid),
    .out_ready(c1_out_ready), .out_idx(c1_out_idx), .out_data(c1_out_data),
    .out_last(c1_out_last));

  lut_sweep_engine #(.N_IN(8), .N_OUT(4)) u_c8 (
    .clk(clk), .rst(rst), .cfg_we(c8_cfg_we), .cfg_addr(c8_cfg_addr), .cfg_data(c8_cfg_data),
    .in_valid(zero_valid), .in_vec(zero_vec8), .in_ready(c8_in_ready),
    .sweep_start(c8_sweep_start), .busy(c8_busy), .done(c8_done), .out_valid(c8_out_valid),
    .out_ready(c8_out_ready), .out_idx(c8_out_idx), .out_data(c8_out_data),
    .out_last(c8_out_last));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the main instance ----------------
  int m_state;
  int m_table [DEPTH];
  int m_ov, m_idx, m_data, m_last, m_done;

  function automatic int model_in_ready();
    return int'((m_state == S_IDLE) && !sweep_start && (m_ov == 0 || out_ready));
  endfunction

  task automatic model_reset();
    m_state = S_IDLE;
    foreach (m_table[i]) m_table[i] = 0;
    m_ov = 0; m_idx = 0; m_data = 0; m_last = 0; m_done = 0;
  endtask

  task automatic present(input int ix, input int last);
    m_ov = 1; m_idx = ix; m_data = m_table[ix]; m_last = last;
  endtask

  // Advances the model by one rising edge using the inputs seen at that edge.
  task automatic model_step();
    int rdy = model_in_ready();
    int taken = int'(m_ov == 1 && out_ready);
    m_done = 0;
    case (m_state)
      S_IDLE: begin
        if (sweep_start && (m_ov == 0 || out_ready)) begin
          m_state = S_SWEEP;
          present(0, 0);
        end else if (in_valid && rdy == 1) begin
          present(int'(in_vec), 0);
        end else if (taken == 1) begin
          m_ov = 0;
        end
        if (cfg_we) m_table[cfg_addr] = int'(cfg_data);
      end
      S_SWEEP: begin
        if (taken == 1) begin
          if (m_idx == DEPTH - 1) begin
            m_ov = 0; m_last = 0; m_done = 1; m_state = S_DONE;
          end else begin
            present(m_idx + 1, int'(m_idx + 1 == DEPTH - 1));
          end
        end
      end
      default: m_state = S_IDLE;
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (rst) model_reset();
      else     model_step();
      #1;
      check("out_valid", int'(out_valid), m_ov);
      check("busy", int'(busy), int'(m_state != S_IDLE));
      check("done", int'(done), m_done);
      check("in_ready", int'(in_ready), model_in_ready());
      if (m_ov == 1) begin
        check("out_idx", int'(out_idx), m_idx);
        check("out_data", int'(out_data), m_data);
        check("out_last", int'(out_last), m_last);
      end
    end
  end

  // ---------------- directed helpers (entered and left at a negedge) -------
  int beat_idx[$], beat_data[$], beat_last[$];

  task automatic run_sweep(input string tag, input int backpressure, input int scribble);
    int last_c = -1;
    int done_c = -1;
    beat_idx.delete(); beat_data.delete(); beat_last.delete();
    sweep_start = 1'b1;
    out_ready   = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    in_valid    = 1'b0;
    for (int c = 0; c < 200 && done_c < 0; c++) begin
      out_ready = (backpressure == 0) || (c % 3 == 0);
      cfg_we    = (scribble != 0) && busy;
      cfg_addr  = 3'($urandom_range(0, 7));
      cfg_data  = 2'($urandom_range(0, 3));
      if (done) done_c = c;
      if (out_valid && out_ready) begin
        beat_idx.push_back(int'(out_idx));
        beat_data.push_back(int'(out_data));
        beat_last.push_back(int'(out_last));
        if (out_last) last_c = c;
      end
      @(negedge clk);
    end
    cfg_we = 1'b0;
    check({tag, "_done_seen"}, int'(done_c >= 0), 1);
    check({tag, "_done_after_last"}, done_c, last_c + 1);
    check({tag, "_busy_after_done"}, int'(busy), 0);
    check({tag, "_done_one_cycle"}, int'(done), 0);
  endtask

  task automatic check_beats(input string tag, input int exp [DEPTH]);
    check({tag, "_beats"}, beat_idx.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < beat_idx.size(); i++) begin
      check($sformatf("%s_idx%0d", tag, i), beat_idx[i], i);
      check($sformatf("%s_data%0d", tag, i), beat_data[i], exp[i]);
      check($sformatf("%s_last%0d", tag, i), beat_last[i], int'(i == DEPTH - 1));
    end
  endtask

  // ---------------- corner instances ----------------
  int c_exp [256];

  task automatic corner_load(input int which);
    int depth = (which == 1) ? 2 : 256;
    for (int i = 0; i < depth; i++) begin
      c_exp[i] = (which == 1) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 15));
      if (which == 1) begin
        c1_cfg_we = 1'b1; c1_cfg_addr = 1'(i); c1_cfg_data = 1'(c_exp[i]);
      end else begin
        c8_cfg_we = 1'b1; c8_cfg_addr = 8'(i); c8_cfg_data = 4'(c_exp[i]);
      end
      @(negedge clk);
    end
    c1_cfg_we = 1'b0;
    c8_cfg_we = 1'b0;
  endtask

  task automatic corner_sweep(input int which);
    int depth  = (which == 1) ? 2 : 256;
    int n      = 0;
    int last_c = -1;
    int done_c = -1;
    int v, ix, dt, lst, dn, r;
    if (which == 1) c1_sweep_start = 1'b1; else c8_sweep_start = 1'b1;
    @(negedge clk);
    c1_sweep_start = 1'b0;
    c8_sweep_start = 1'b0;
    for (int c = 0; c < 2000 && done_c < 0; c++) begin
      r = (which == 1) ? 1 : int'($urandom_range(0, 3) != 0);
      if (which == 1) c1_out_ready = 1'(r); else c8_out_ready = 1'(r);
      v   = (which == 1) ? int'(c1_out_valid) : int'(c8_out_valid);
      ix  = (which == 1) ? int'(c1_out_idx)   : int'(c8_out_idx);
      dt  = (which == 1) ? int'(c1_out_data)  : int'(c8_out_data);
      lst = (which == 1) ? int'(c1_out_last)  : int'(c8_out_last);
      dn  = (which == 1) ? int'(c1_done)      : int'(c8_done);
      if (dn == 1) done_c = c;
      if (v == 1 && r == 1) begin
        check($sformatf("c%0d_idx", which), ix, n);
        check($sformatf("c%0d_data", which), dt, (n < depth) ? c_exp[n] : -1);
        check($sformatf("c%0d_last", which), lst, int'(n == depth - 1));
        if (lst == 1) last_c = c;
        n++;
      end
      @(negedge clk);
    end
    check($sformatf("c%0d_beats", which), n, depth);
    check($sformatf("c%0d_done_after_last", which), done_c, last_c + 1);
    check($sformatf("c%0d_busy_after", which),
          (which == 1) ? int'(c1_busy) : int'(c8_busy), 0);
  endtask

  // ---------------- main stimulus ----------------
  int fn      [DEPTH] = '{1, 3, 0, 2, 1, 2, 3, 1};
  int fn_mod  [DEPTH] = '{1, 3, 0, 2, 1, 1, 3, 1};
  int fn_zero [DEPTH] = '{0, 0, 0, 0, 0, 0, 0, 0};

  initial begin
    rst = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; in_vec = '0; sweep_start = 1'b0; out_ready = 1'b0;
    c1_cfg_we = 1'b0; c1_cfg_addr = '0; c1_cfg_data = '0;
    c1_sweep_start = 1'b0; c1_out_ready = 1'b1;
    c8_cfg_we = 1'b0; c8_cfg_addr = '0; c8_cfg_data = '0;
    c8_sweep_start = 1'b0; c8_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_idx", int'(out_idx), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);

    // Load the reference function and sweep it, free-running then throttled.
    for (int i = 0; i < DEPTH; i++) begin
      cfg_we = 1'b1; cfg_addr = 3'(i); cfg_data = 2'(fn[i]);
      @(negedge clk);
    end
    cfg_we = 1'b0;
    run_sweep("sweep", 0, 0);
    check_beats("sweep", fn);
    run_sweep("bp", 1, 0);
    check_beats("bp", fn);

    // Write and lookup of entry 5 in the same cycle: old contents come back.
    cfg_we = 1'b1; cfg_addr = 3'd5; cfg_data = 2'b01;
    in_valid = 1'b1; in_vec = 3'd5; out_ready = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0;
    check("collide_valid", int'(out_valid), 1);
    check("collide_old_data", int'(out_data), 2);
    @(negedge clk);
    in_valid = 1'b0;
    check("relookup_data", int'(out_data), 1);
    @(negedge clk);

    // Sweep request beats a simultaneous lookup; writes during the sweep drop.
    in_valid = 1'b1; in_vec = 3'd2; sweep_start = 1'b1;
    #1;
    check("prio_in_ready", int'(in_ready), 0);
    run_sweep("prio", 0, 1);
    check_beats("prio", fn_mod);
    run_sweep("after_scribble", 0, 0);
    check_beats("after_scribble", fn_mod);

    // Random traffic, compared against the model every cycle.
    for (int c = 0; c < 800; c++) begin
      cfg_we      = ($urandom_range(0, 3) == 0);
      cfg_addr    = 3'($urandom_range(0, 7));
      cfg_data    = 2'($urandom_range(0, 3));
      in_valid    = 1'($urandom_range(0, 1));
      in_vec      = 3'($urandom_range(0, 7));
      sweep_start = ($urandom_range(0, 24) == 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    cfg_we = 1'b0; in_valid = 1'b0; sweep_start = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 40 && (busy || out_valid); c++) @(negedge clk);
    check("drain_idle", int'(busy || out_valid), 0);

    // Reset in the middle of a sweep.
    sweep_start = 1'b1;
    @(negedge clk);
    sweep_start = 1'b0;
    for (int c = 0; c < 40 && !(out_valid && out_idx == 3'd3); c++) @(negedge clk);
    check("reached_beat3", int'(out_valid && out_idx == 3'd3), 1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_out_last", int'(out_last), 0);
    check("midrst_out_idx", int'(out_idx), 0);
    check("midrst_out_data", int'(out_data), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_sweep("post_rst", 0, 0);
    check_beats("post_rst", fn_zero);

    // Parameter corners.
    corner_load(1);
    corner_sweep(1);
    corner_load(8);
    corner_sweep(8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lut_sweep_engine.md
# lut_sweep_engine

Programmable truth-table unit: a `2**N_IN`-entry by `N_OUT`-bit lookup table that replaces hand-written sum-of-products blocks. Software loads any N-input/M-output Boolean function through a write port. The block then answers single lookups, or autonomously sweeps every input combination `0..2**N_IN-1` and streams the full truth table out through a valid/ready handshake. It sits between the configuration bus and the result logger/checker.

## Interface
- `N_IN`, default 3: number of function inputs; legal range 1..8; table depth is `2**N_IN`.
- `N_OUT`, default 2: number of function outputs; legal range 1..16.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `cfg_we` input 1: table write strobe.
- `cfg_addr` input N_IN: table entry to write; the input combination, MSB = first input.
- `cfg_data` input N_OUT: output vector for that entry.
- `in_valid` input 1: single-lookup request.
- `in_vec` input N_IN: input combination to look up.
- `in_ready` output 1: lookup accepted when `in_valid && in_ready`.
- `sweep_start` input 1: request a full truth-table sweep.
- `busy` output 1: high in states SWEEP and DONE.
- `done` output 1: one-cycle pulse at sweep completion.
- `out_valid` output 1: output beat valid.
- `out_ready` input 1: consumer accepts the beat.
- `out_idx` output N_IN: input combination of the current beat.
- `out_data` output N_OUT: table contents at `out_idx`.
- `out_last` output 1: high on the final sweep beat (`out_idx == 2**N_IN-1` in SWEEP); always 0 for lookups.

## Operation
- Reset clears all table entries to 0 and all outputs to 0. State goes to IDLE and the sweep counter to 0.
- Writes are accepted only in IDLE. `cfg_we` while `busy` is dropped.
- A write is visible from the next cycle. A lookup or sweep start in the same cycle as a write to the same address returns the old contents.
- FSM states: IDLE, SWEEP, DONE.
- IDLE → SWEEP on `sweep_start`. The counter loads 0.
- SWEEP: the output register presents `{counter, table[counter]}`. On each `out_valid && out_ready` handshake the counter increments.
- After the handshake with `out_last` = 1, SWEEP → DONE.
- DONE: `done` = 1 for exactly one cycle, then the FSM returns to IDLE.
- `sweep_start` outside IDLE is ignored.
- Lookup: `in_ready = (state == IDLE) && !sweep_start && (!out_valid || out_ready)`.
  - On acceptance the output register loads `{in_vec, table[in_vec]}` and `out_valid` rises.
- In IDLE, `sweep_start` has priority over a simultaneous lookup. The lookup is not accepted because `in_ready` is 0.
- Output-register rules:
  - `out_idx`, `out_data` and `out_last` are stable while `out_valid && !out_ready`.
  - `out_valid` drops after the handshake unless a new beat loads in the same cycle.
  - A pending lookup beat must drain before a sweep starts: `sweep_start` is ignored while `out_valid` holds an unaccepted lookup result.
- Counter wrap: the counter is N_IN+1 bits wide internally, or `out_last` is detected before wrap. The sweep emits exactly `2**N_IN` beats and never repeats index 0.

## Timing
- Lookup latency: accepted at edge T → `out_valid` = 1 after edge T. Back-to-back lookups sustain one per cycle when `out_ready` is held at 1.
- Sweep: `sweep_start` sampled at edge T → first beat (`out_idx` = 0) valid after edge T.
- With `out_ready` held at 1, the last beat is presented `2**N_IN - 1` cycles after the first. `done` is high on the next cycle.
- `busy` rises the cycle after `sweep_start` is sampled and falls together with `done`.
- Asserting `rst` mid-sweep immediately drops `out_valid`, `busy`, `done` and `out_last`, and clears the table. Normal operation resumes on the first edge after `rst` deasserts.

## Test plan
- Load function, N_IN=3, N_OUT=2: write entries 0..7 = 01, 11, 00, 10, 01, 10, 11, 01. Then sweep with `out_ready`=1.
  - Required: 8 beats, `out_idx` 0..7 with those `out_data` values, `out_last` only on idx 7.
  - Required: `done` pulse one cycle after beat 7, `busy` low thereafter.
- Backpressure: repeat the sweep with `out_ready` toggled 1,0,0,1…
  - Required: each beat is held unchanged while ready=0; no index is skipped or duplicated; still exactly 8 beats.
- Lookup with write collision: table[5]=10. In one cycle, `cfg_we` to addr 5 with data 01 and `in_valid` with `in_vec`=5 → `out_data`=10.
  - The next lookup of 5 → 01.
- Priority and busy gating:
  - `sweep_start` and `in_valid` in the same IDLE cycle → `in_ready`=0 and the sweep runs.
  - `cfg_we` during the sweep → the table is unchanged after the sweep completes.
- Reset mid-sweep: assert `rst` at beat 3.
  - Required: all outputs 0 at once.
  - Required: a post-reset sweep returns all-zero `out_data` for idx 0..7.
- Parameter corners: N_IN=1, N_OUT=1 → 2-beat sweep with `out_last` on idx 1.
  - Check: N_IN=8 → 256 beats, counter does not wrap, `done` after idx 255.
